// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : adsr_envelope
// Description : ADSR gain envelope with registered sample scaling.
//               Optional macro ADSR_EXP_RELEASE_EN selects an exponential-like
//               release tail instead of a linear one.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 16,
    parameter int EXP_SHIFT  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  play,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [GAIN_WIDTH-1:0] attack_step,
    input  logic [GAIN_WIDTH-1:0] decay_step,
    input  logic [GAIN_WIDTH-1:0] sustain_level,
    input  logic [GAIN_WIDTH-1:0] release_step,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [GAIN_WIDTH-1:0] gain_out,
    output logic [2:0]            stage,
    output logic                  active
);

    localparam int                  c_PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [GAIN_WIDTH-1:0] c_GMAX     = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [GAIN_WIDTH-1:0]   r_gain;
    logic [GAIN_WIDTH-1:0]   w_gain_next;
    logic                    r_active;
    logic [DATA_WIDTH-1:0]   r_data_out;

    logic [GAIN_WIDTH:0]     w_attack_sum;
    logic [GAIN_WIDTH-1:0]   w_decay_room;
    logic [GAIN_WIDTH-1:0]   w_release_dec;
    logic                    w_release_now;

    logic signed [c_PROD_WIDTH-1:0] w_data_ext;
    logic signed [c_PROD_WIDTH-1:0] w_gain_ext;
    logic signed [c_PROD_WIDTH-1:0] w_product;

    // One extra bit so the attack sum can exceed GMAX before clamping
    assign w_attack_sum = {1'b0, r_gain} + {1'b0, attack_step};
    assign w_decay_room = r_gain - sustain_level;

`ifdef ADSR_EXP_RELEASE_EN
    logic [GAIN_WIDTH-1:0] w_exp_dec;

    assign w_exp_dec = r_gain >> EXP_SHIFT;

    always_comb begin
        w_release_dec = (release_step > w_exp_dec) ? release_step : w_exp_dec;
        // Guarantee forward progress once the shifted gain rounds to zero
        if ((w_release_dec == '0) && (r_gain != '0)) begin
            w_release_dec = GAIN_WIDTH'(1);
        end
    end

    assign w_release_now = 1'b0;
`else
    assign w_release_dec = release_step;
    assign w_release_now = (release_step == '0);
`endif

    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        case (r_state)
            ST_IDLE: begin
                w_gain_next = '0;
                if (play) begin
                    w_state_next = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (!play) begin
                    w_state_next = ST_RELEASE;
                end else if (attack_step == '0) begin
                    w_gain_next  = c_GMAX;
                    w_state_next = ST_DECAY;
                end else if (sample_tick) begin
                    if (w_attack_sum >= {1'b0, c_GMAX}) begin
                        w_gain_next  = c_GMAX;
                        w_state_next = ST_DECAY;
                    end else begin
                        w_gain_next = w_attack_sum[GAIN_WIDTH-1:0];
                    end
                end
            end
            ST_DECAY: begin
                if (!play) begin
                    w_state_next = ST_RELEASE;
                end else if ((decay_step == '0) || (sustain_level >= r_gain)) begin
                    w_gain_next  = sustain_level;
                    w_state_next = ST_SUSTAIN;
                end else if (sample_tick) begin
                    if (decay_step >= w_decay_room) begin
                        w_gain_next  = sustain_level;
                        w_state_next = ST_SUSTAIN;
                    end else begin
                        w_gain_next = r_gain - decay_step;
                    end
                end
            end
            ST_SUSTAIN: begin
                if (!play) begin
                    w_state_next = ST_RELEASE;
                end else begin
                    w_gain_next = sustain_level;
                end
            end
            ST_RELEASE: begin
                // Retrigger keeps the current gain so the attack ramps from here
                if (play) begin
                    w_state_next = ST_ATTACK;
                end else if (w_release_now) begin
                    w_gain_next  = '0;
                    w_state_next = ST_IDLE;
                end else if (sample_tick) begin
                    if (r_gain <= w_release_dec) begin
                        w_gain_next  = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_gain_next = r_gain - w_release_dec;
                    end
                end
            end
            default: begin
                w_gain_next  = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_gain   <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_gain   <= w_gain_next;
            r_active <= (w_state_next != ST_IDLE);
        end
    end

    // Gain is zero-extended so the product stays signed and never overflows
    assign w_data_ext = {{(GAIN_WIDTH + 1){data_in[DATA_WIDTH-1]}}, data_in};
    assign w_gain_ext = {{(DATA_WIDTH + 1){1'b0}}, r_gain};
    assign w_product  = w_data_ext * w_gain_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= DATA_WIDTH'(w_product >>> GAIN_WIDTH);
        end
    end

    assign data_out = r_data_out;
    assign gain_out = r_gain;
    assign stage    = r_state;
    assign active   = r_active;

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : tb_adsr_envelope
// Description : Directed self-checking bench for adsr_envelope.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic        play;
    logic [31:0] data_in;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [31:0] data_out;
    logic [15:0] gain_out;
    logic [2:0]  stage;
    logic        active;

    int n_checks;
    int n_fail;

    adsr_envelope #(
        .DATA_WIDTH (32),
        .GAIN_WIDTH (16),
        .EXP_SHIFT  (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .play          (play),
        .data_in       (data_in),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .data_out      (data_out),
        .gain_out      (gain_out),
        .stage         (stage),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; play = 1'b0; sample_tick = 1'b1; data_in = 32'd1234;
        attack_step = 16'd0; decay_step = 16'd0; sustain_level = 16'd0; release_step = 16'd0;
        cyc(); cyc();
        n_checks++; if (gain_out !== 16'd0) begin n_fail++; $display("FAIL reset_gain: got %0d expected 0", gain_out); end
        n_checks++; if (stage !== 3'd0) begin n_fail++; $display("FAIL reset_stage: got %0d expected 0", stage); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b expected 0", active); end
        n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", data_out); end
    endtask

    task automatic test_attack();
        logic [15:0] exp_g [4];
        logic [2:0]  exp_s [4];
        exp_g = '{16'd16384, 16'd32768, 16'd49152, 16'd65535};
        exp_s = '{3'd1, 3'd1, 3'd1, 3'd2};
        attack_step = 16'd16384; decay_step = 16'd10000;
        sustain_level = 16'd40000; release_step = 16'd20000;
        data_in = 32'd0; rst_n = 1'b1; play = 1'b1;
        cyc();
        n_checks++; if (stage !== 3'd1) begin n_fail++; $display("FAIL attack_enter_stage: got %0d expected 1", stage); end
        n_checks++; if (gain_out !== 16'd0) begin n_fail++; $display("FAIL attack_enter_gain: got %0d expected 0", gain_out); end
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL attack_active: got %0b expected 1", active); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++; if (gain_out !== exp_g[i]) begin n_fail++; $display("FAIL attack_gain[%0d]: got %0d expected %0d", i, gain_out, exp_g[i]); end
            n_checks++; if (stage !== exp_s[i]) begin n_fail++; $display("FAIL attack_stage[%0d]: got %0d expected %0d", i, stage, exp_s[i]); end
        end
    endtask

    task automatic test_decay();
        logic [15:0] exp_g [3];
        logic [2:0]  exp_s [3];
        exp_g = '{16'd55535, 16'd45535, 16'd40000};
        exp_s = '{3'd2, 3'd2, 3'd3};
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (gain_out !== exp_g[i]) begin n_fail++; $display("FAIL decay_gain[%0d]: got %0d expected %0d", i, gain_out, exp_g[i]); end
            n_checks++; if (stage !== exp_s[i]) begin n_fail++; $display("FAIL decay_stage[%0d]: got %0d expected %0d", i, stage, exp_s[i]); end
        end
        sustain_level = 16'd30000;
        cyc();
        n_checks++; if (gain_out !== 16'd30000) begin n_fail++; $display("FAIL sustain_live: got %0d expected 30000", gain_out); end
        sustain_level = 16'd40000;
        cyc();
        n_checks++; if (gain_out !== 16'd40000) begin n_fail++; $display("FAIL sustain_back: got %0d expected 40000", gain_out); end
    endtask

    task automatic test_release();
        play = 1'b0;
        cyc();
        n_checks++; if (stage !== 3'd4) begin n_fail++; $display("FAIL release_stage: got %0d expected 4", stage); end
        n_checks++; if (gain_out !== 16'd40000) begin n_fail++; $display("FAIL release_start: got %0d expected 40000", gain_out); end
        cyc();
        n_checks++; if (gain_out !== 16'd20000) begin n_fail++; $display("FAIL release_g1: got %0d expected 20000", gain_out); end
        cyc();
        n_checks++; if (gain_out !== 16'd0) begin n_fail++; $display("FAIL release_g2: got %0d expected 0", gain_out); end
        n_checks++; if (stage !== 3'd0) begin n_fail++; $display("FAIL release_idle: got %0d expected 0", stage); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL release_active: got %0b expected 0", active); end
    endtask

    task automatic test_retrigger();
        attack_step = 16'd0; decay_step = 16'd0; play = 1'b1;
        cyc();
        n_checks++; if (stage !== 3'd1) begin n_fail++; $display("FAIL rt_attack: got %0d expected 1", stage); end
        cyc();
        n_checks++; if (gain_out !== 16'd65535) begin n_fail++; $display("FAIL rt_zero_attack_gain: got %0d expected 65535", gain_out); end
        n_checks++; if (stage !== 3'd2) begin n_fail++; $display("FAIL rt_zero_attack_stage: got %0d expected 2", stage); end
        cyc();
        n_checks++; if (gain_out !== 16'd40000) begin n_fail++; $display("FAIL rt_zero_decay_gain: got %0d expected 40000", gain_out); end
        n_checks++; if (stage !== 3'd3) begin n_fail++; $display("FAIL rt_zero_decay_stage: got %0d expected 3", stage); end
        play = 1'b0;
        cyc();
        sample_tick = 1'b0;
        cyc(); cyc();
        n_checks++; if (gain_out !== 16'd40000) begin n_fail++; $display("FAIL rt_no_tick_hold: got %0d expected 40000", gain_out); end
        sample_tick = 1'b1;
        cyc();
        n_checks++; if (gain_out !== 16'd20000) begin n_fail++; $display("FAIL rt_release_gain: got %0d expected 20000", gain_out); end
        play = 1'b1; attack_step = 16'd16384;
        cyc();
        n_checks++; if (stage !== 3'd1) begin n_fail++; $display("FAIL rt_stage: got %0d expected 1", stage); end
        n_checks++; if (gain_out !== 16'd20000) begin n_fail++; $display("FAIL rt_no_jump: got %0d expected 20000", gain_out); end
        cyc();
        n_checks++; if (gain_out !== 16'd36384) begin n_fail++; $display("FAIL rt_ramp: got %0d expected 36384", gain_out); end
    endtask

    task automatic test_scaling();
        attack_step = 16'd0;
        cyc();
        n_checks++; if (gain_out !== 16'd65535) begin n_fail++; $display("FAIL sc_peak: got %0d expected 65535", gain_out); end
        sustain_level = 16'd32768; decay_step = 16'd0;
        cyc();
        n_checks++; if (gain_out !== 16'd32768) begin n_fail++; $display("FAIL sc_half_gain: got %0d expected 32768", gain_out); end
        data_in = 32'd1000;
        cyc();
        n_checks++; if ($signed(data_out) !== 32'sd500) begin n_fail++; $display("FAIL sc_pos_half: got %0d expected 500", $signed(data_out)); end
        data_in = -32'sd1000;
        cyc();
        n_checks++; if ($signed(data_out) !== -32'sd500) begin n_fail++; $display("FAIL sc_neg_half: got %0d expected -500", $signed(data_out)); end
        sustain_level = 16'd65535; data_in = 32'd0;
        cyc();
        n_checks++; if (gain_out !== 16'd65535) begin n_fail++; $display("FAIL sc_full_gain: got %0d expected 65535", gain_out); end
        data_in = 32'd100000;
        cyc();
        n_checks++; if ($signed(data_out) !== 32'sd99998) begin n_fail++; $display("FAIL sc_pos_full: got %0d expected 99998", $signed(data_out)); end
        data_in = -32'sd100000;
        cyc();
        n_checks++; if ($signed(data_out) !== -32'sd99999) begin n_fail++; $display("FAIL sc_neg_full: got %0d expected -99999", $signed(data_out)); end
    endtask

    task automatic test_mid_reset();
        sustain_level = 16'd40000; data_in = 32'd1000;
        cyc();
        n_checks++; if (gain_out !== 16'd40000) begin n_fail++; $display("FAIL mr_pre_gain: got %0d expected 40000", gain_out); end
        rst_n = 1'b0;
        cyc();
        n_checks++; if (gain_out !== 16'd0) begin n_fail++; $display("FAIL mr_gain: got %0d expected 0", gain_out); end
        n_checks++; if (stage !== 3'd0) begin n_fail++; $display("FAIL mr_stage: got %0d expected 0", stage); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL mr_active: got %0b expected 0", active); end
        n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL mr_data: got %0d expected 0", data_out); end
    endtask

    task automatic test_release_step();
        logic [15:0] exp_g1;
        logic [15:0] exp_g2;
        logic [2:0]  exp_s2;
`ifdef ADSR_EXP_RELEASE_EN
        exp_g1 = 16'd64512; exp_g2 = 16'd63504; exp_s2 = 3'd4;
`else
        exp_g1 = 16'd65534; exp_g2 = 16'd0;     exp_s2 = 3'd0;
`endif
        rst_n = 1'b1; play = 1'b1; attack_step = 16'd0; decay_step = 16'd0;
        release_step = 16'd1; data_in = 32'd0;
        cyc(); cyc();
        n_checks++; if (gain_out !== 16'd65535) begin n_fail++; $display("FAIL rs_peak: got %0d expected 65535", gain_out); end
        play = 1'b0;
        cyc();
        n_checks++; if (stage !== 3'd4) begin n_fail++; $display("FAIL rs_gate_priority: got %0d expected 4", stage); end
        n_checks++; if (gain_out !== 16'd65535) begin n_fail++; $display("FAIL rs_start: got %0d expected 65535", gain_out); end
        cyc();
        n_checks++; if (gain_out !== exp_g1) begin n_fail++; $display("FAIL rs_first_dec: got %0d expected %0d", gain_out, exp_g1); end
        release_step = 16'd0;
        cyc();
        n_checks++; if (gain_out !== exp_g2) begin n_fail++; $display("FAIL rs_zero_step_gain: got %0d expected %0d", gain_out, exp_g2); end
        n_checks++; if (stage !== exp_s2) begin n_fail++; $display("FAIL rs_zero_step_stage: got %0d expected %0d", stage, exp_s2); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_retrigger();
        test_scaling();
        test_mid_reset();
        test_release_step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
